z80_mem_xfer_seq: RTL and testbench
===================================

# z80_mem_xfer_seq

Parametrised multi-byte memory transfer sequencer for the Z80 core. It carries out the memory side of wide loads and stores such as LD (nn),dd and LD dd,(nn), and is generalised to 1..MAX_BYTES bytes per transfer, either read or write, with selectable byte order. It issues one byte-wide bus cycle per byte with fixed T-state length and WAIT stretching. On completion it presents the per-byte address and data, which the Z80FI trace uses to generalise the mem_waddr/waddr2 pairs.

## Interface
Parameters:
- MAX_BYTES, 2: maximum bytes per transfer; legal range 1..4.
- BIG_ENDIAN, 0: 0 means byte i of the value goes to addr+i; 1 means byte len-1-i goes to addr+i.
- T_STATES, 3: clock cycles per byte access; minimum 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  transfer request.
- req_ready  out  1  high only in IDLE; accept = req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  16  base address nn.
- req_len  in  3  byte count; 0 is legal; values above MAX_BYTES are clamped to MAX_BYTES.
- req_wdata  in  8*MAX_BYTES  value to write; byte k is [8k+7:8k].
- mem_addr  out  16  current byte address.
- mem_wdata  out  8  current write byte.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_wait  in  1  active-high stall; sampled on the last T-state of each access.
- mem_rdata  in  8  read byte.
- done  out  1  one-cycle completion pulse.
- rdata  out  8*MAX_BYTES  assembled read value, using the same byte order rule as writes.
- xfer_addr  out  16*MAX_BYTES  address of byte slot i (address order).
- xfer_data  out  8*MAX_BYTES  data of byte slot i (address order), for reads and writes.
- xfer_count  out  3  number of bytes actually transferred.

## Operation
- States: IDLE, ACCESS, DONE.
- Reset: state IDLE. All outputs are 0 except req_ready=1. Reset in any state aborts the transfer on that edge:
  - strobes go low and no done is issued;
  - rdata, xfer_* and xfer_count are cleared.
- IDLE, on accept:
  - latch write flag, addr, clamped len and wdata;
  - clear rdata, xfer_* and xfer_count;
  - byte index i=0, T-counter t=0;
  - go to ACCESS if len>0, else go to DONE.
- ACCESS:
  - mem_addr = (req_addr + i) mod 2^16; 0xFFFF wraps to 0x0000.
  - mem_wdata = value byte i (little-endian) or byte len-1-i (big-endian).
  - Exactly one of mem_rd/mem_wr is high for the whole access, including wait cycles.
  - t counts 0..T_STATES-1. At t=T_STATES-1 with mem_wait=1, t holds (one added cycle per wait cycle).
  - At t=T_STATES-1 with mem_wait=0, the access ends:
    - a read captures mem_rdata into rdata and xfer_data slot i;
    - xfer_addr slot i is written;
    - xfer_count increments;
    - if i=len-1, go to DONE, else set i+1 and t=0.
- Consecutive accesses are back-to-back. Strobes do not drop between bytes; only mem_addr and mem_wdata change.
- DONE:
  - done=1 and req_ready=0 for exactly one cycle, then go to IDLE.
  - rdata, xfer_* and xfer_count hold until the next accept.
- mem_addr and mem_wdata are 0 whenever no strobe is high.
- Slots at or beyond xfer_count read as 0.

## Timing
- Accept on edge E0:
  - ACCESS byte 0 is visible in cycle 1;
  - byte k occupies cycles k*T_STATES+1 .. (k+1)*T_STATES when there are no waits.
- Latency with no waits: done in cycle len*T_STATES+1; req_ready high again in cycle len*T_STATES+2.
- len=0: done in cycle 1 and no strobes.
- Each wait cycle delays every later event by exactly 1 cycle.
- A request asserted while req_ready=0 is ignored. req_valid held through DONE is accepted in the first IDLE cycle.

## Test plan
- LD (nn),dd case: write, addr 0x1234, len 2, wdata 0xBEEF, BIG_ENDIAN=0, T=3, no waits. Required:
  - mem_wr cycles 1-3 with addr 0x1234, data 0xEF;
  - cycles 4-6 with addr 0x1235, data 0xBE;
  - done in cycle 7;
  - xfer_addr={0x1235,0x1234}, xfer_data={0xBE,0xEF}, xfer_count=2.
- Wrap plus big-endian: read, addr 0xFFFF, len 2, BIG_ENDIAN=1, memory[0xFFFF]=0x12 and [0x0000]=0x34. Required: second access at 0x0000, rdata=0x1234, done in cycle 7.
- Wait: mem_wait high for 2 cycles at byte 0's last T-state, len 2. Required: byte 0 ends in cycle 5, done in cycle 9, strobe continuous.
- len=0 and len=7 with MAX_BYTES=4. Required:
  - len=0: done in cycle 1, no strobes, xfer_count=0;
  - len=7: exactly 4 accesses, xfer_count=4.
- Reset asserted in cycle 4 of a 2-byte write. Required: strobes low from cycle 5, no done, req_ready=1, xfer_count=0; a new request is then accepted normally.
- Back-to-back requests with req_valid held high. Required: second accept in the cycle after done, and stale rdata cleared on that accept.

Source files
------------

// File: rtl/z80_mem_xfer_seq.sv
// Byte-serial memory transfer sequencer for wide Z80 loads/stores (1..MAX_BYTES bytes).
// Issues one fixed-length, WAIT-stretchable bus access per byte and records per-slot address/data.
module z80_mem_xfer_seq #(
  parameter int MAX_BYTES  = 2,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int T_STATES   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [15:0]              req_addr,
  input  logic [2:0]               req_len,
  input  logic [8*MAX_BYTES-1:0]   req_wdata,
  output logic [15:0]              mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     mem_rd,
  output logic                     mem_wr,
  input  logic                     mem_wait,
  input  logic [7:0]               mem_rdata,
  output logic                     done,
  output logic [8*MAX_BYTES-1:0]   rdata,
  output logic [16*MAX_BYTES-1:0]  xfer_addr,
  output logic [8*MAX_BYTES-1:0]   xfer_data,
  output logic [2:0]               xfer_count
);

  localparam int              TW      = $clog2(T_STATES);
  localparam logic [TW-1:0]   T_LAST  = TW'(T_STATES - 1);
  localparam logic [2:0]      LEN_MAX = 3'(MAX_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [15:0]             base_q, base_d;
  logic [2:0]              len_q, len_d;
  logic [8*MAX_BYTES-1:0]  wdata_q, wdata_d;
  logic [2:0]              idx_q, idx_d;
  logic [TW-1:0]           t_q, t_d;

  logic                    req_ready_q, req_ready_d;
  logic                    done_q, done_d;
  logic                    mem_rd_q, mem_rd_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [15:0]             mem_addr_q, mem_addr_d;
  logic [7:0]              mem_wdata_q, mem_wdata_d;
  logic [8*MAX_BYTES-1:0]  rdata_q, rdata_d;
  logic [16*MAX_BYTES-1:0] xfer_addr_q, xfer_addr_d;
  logic [8*MAX_BYTES-1:0]  xfer_data_q, xfer_data_d;
  logic [2:0]              xfer_count_q, xfer_count_d;

  logic [15:0]             cur_addr;
  logic [2:0]              cur_vidx;
  logic                    strobe;

  // Value byte that belongs at address base+i under the configured byte order.
  function automatic logic [2:0] val_idx(input logic [2:0] len, input logic [2:0] i);
    if (BIG_ENDIAN) val_idx = len - 3'd1 - i;
    else            val_idx = i;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [8*MAX_BYTES-1:0] v, input logic [2:0] k);
    pick_byte = 8'h00;
    for (int j = 0; j < MAX_BYTES; j++) begin
      if (3'(j) == k) pick_byte = v[8*j +: 8];
    end
  endfunction

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    base_d       = base_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    t_d          = t_q;
    rdata_d      = rdata_q;
    xfer_addr_d  = xfer_addr_q;
    xfer_data_d  = xfer_data_q;
    xfer_count_d = xfer_count_q;
    cur_addr     = base_q + {13'd0, idx_q};
    cur_vidx     = val_idx(len_q, idx_q);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d      = req_write;
          base_d       = req_addr;
          len_d        = (req_len > LEN_MAX) ? LEN_MAX : req_len;
          wdata_d      = req_wdata;
          idx_d        = 3'd0;
          t_d          = '0;
          rdata_d      = '0;
          xfer_addr_d  = '0;
          xfer_data_d  = '0;
          xfer_count_d = 3'd0;
          state_d      = (len_d == 3'd0) ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (t_q != T_LAST) begin
          t_d = t_q + 1'b1;
        end else if (!mem_wait) begin
          for (int j = 0; j < MAX_BYTES; j++) begin
            if (3'(j) == idx_q) begin
              xfer_addr_d[16*j +: 16] = cur_addr;
              xfer_data_d[8*j +: 8]   = write_q ? pick_byte(wdata_q, cur_vidx) : mem_rdata;
            end
            if (!write_q && 3'(j) == cur_vidx) rdata_d[8*j +: 8] = mem_rdata;
          end
          xfer_count_d = xfer_count_q + 3'd1;
          if (idx_q == len_q - 3'd1) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
            t_d   = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    strobe      = (state_d == S_ACCESS);
    req_ready_d = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
    mem_rd_d    = strobe && !write_d;
    mem_wr_d    = strobe && write_d;
    mem_addr_d  = strobe ? (base_d + {13'd0, idx_d}) : 16'h0000;
    mem_wdata_d = (strobe && write_d) ? pick_byte(wdata_d, val_idx(len_d, idx_d)) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      base_q       <= 16'h0000;
      len_q        <= 3'd0;
      wdata_q      <= '0;
      idx_q        <= 3'd0;
      t_q          <= '0;
      req_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 8'h00;
      rdata_q      <= '0;
      xfer_addr_q  <= '0;
      xfer_data_q  <= '0;
      xfer_count_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      base_q       <= base_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      t_q          <= t_d;
      req_ready_q  <= req_ready_d;
      done_q       <= done_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      xfer_addr_q  <= xfer_addr_d;
      xfer_data_q  <= xfer_data_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign done       = done_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rdata      = rdata_q;
  assign xfer_addr  = xfer_addr_q;
  assign xfer_data  = xfer_data_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_z80_mem_xfer_seq.sv
// Scoreboard bench: two instances (little/big-endian, MAX_BYTES=4, T_STATES=3) driven with
// directed transfers; a negedge monitor checks every bus cycle and every completion against queues.
module tb_z80_mem_xfer_seq;

  localparam int MB = 4;
  localparam int T  = 3;

  typedef struct {
    int          g;
    int          cyc;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_t;

  typedef struct {
    int          g;
    int          cyc;
    logic [31:0] rdata;
    logic [63:0] xaddr;
    logic [31:0] xdata;
    logic [2:0]  cnt;
  } cmp_t;

  logic        clk;
  logic        reset_v   [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [15:0] req_addr  [2];
  logic [2:0]  req_len   [2];
  logic [31:0] req_wdata [2];
  logic [15:0] mem_addr  [2];
  logic [7:0]  mem_wdata [2];
  logic        mem_rd    [2];
  logic        mem_wr    [2];
  logic        mem_wait  [2];
  logic [7:0]  mem_rdata [2];
  logic        done      [2];
  logic [31:0] rdata     [2];
  logic [63:0] xfer_addr [2];
  logic [31:0] xfer_data [2];
  logic [2:0]  xfer_count[2];

  logic [7:0]  mem0 [65536];
  logic [7:0]  mem1 [65536];

  bus_t bus_q[$];
  cmp_t cmp_q[$];
  bus_t mb;
  cmp_t mc;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;
  bit mon_on = 0;
  int w_g = -1;
  int w_lo = 0;
  int w_hi = -1;

  assign mem_rdata[0] = mem0[mem_addr[0]];
  assign mem_rdata[1] = mem1[mem_addr[1]];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    z80_mem_xfer_seq #(.MAX_BYTES(MB), .BIG_ENDIAN(g == 1), .T_STATES(T)) u_dut (
      .clk(clk), .reset(reset_v[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_len(req_len[g]), .req_wdata(req_wdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]),
      .mem_wait(mem_wait[g]), .mem_rdata(mem_rdata[g]),
      .done(done[g]), .rdata(rdata[g]), .xfer_addr(xfer_addr[g]), .xfer_data(xfer_data[g]),
      .xfer_count(xfer_count[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) mem_wait[g] = (g == w_g) && (cyc >= w_lo) && (cyc <= w_hi);
    end
  end

  // Monitor: one bus expectation per strobed cycle, one completion expectation per done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        for (int g = 0; g < 2; g++) begin
          n_vec++;
          if (mem_rd[g] === 1'b1 || mem_wr[g] === 1'b1) begin
            if (bus_q.size() == 0 || bus_q[0].g != g) begin
              n_miss++;
              $display("FAIL bus%0d unexpected strobe cyc=%0d rd=%b wr=%b addr=%h data=%h",
                       g, cyc, mem_rd[g], mem_wr[g], mem_addr[g], mem_wdata[g]);
            end else begin
              mb = bus_q.pop_front();
              if (mb.cyc != cyc || mb.rd !== mem_rd[g] || mb.wr !== mem_wr[g] ||
                  mb.addr !== mem_addr[g] || mb.data !== mem_wdata[g]) begin
                n_miss++;
                $display("FAIL bus%0d got cyc=%0d rd=%b wr=%b addr=%h data=%h, expected cyc=%0d rd=%b wr=%b addr=%h data=%h",
                         g, cyc, mem_rd[g], mem_wr[g], mem_addr[g], mem_wdata[g],
                         mb.cyc, mb.rd, mb.wr, mb.addr, mb.data);
              end
            end
          end else begin
            if (mem_rd[g] !== 1'b0 || mem_wr[g] !== 1'b0 || mem_addr[g] !== 16'h0 || mem_wdata[g] !== 8'h0) begin
              n_miss++;
              $display("FAIL idle_bus%0d cyc=%0d got rd=%b wr=%b addr=%h data=%h, expected all 0",
                       g, cyc, mem_rd[g], mem_wr[g], mem_addr[g], mem_wdata[g]);
            end else if (bus_q.size() > 0 && bus_q[0].g == g && bus_q[0].cyc <= cyc) begin
              mb = bus_q.pop_front();
              n_miss++;
              $display("FAIL bus%0d missing strobe at cyc=%0d: got none, expected addr=%h", g, mb.cyc, mb.addr);
            end
          end
          if (done[g] !== 1'b0) begin
            n_vec++;
            if (cmp_q.size() == 0 || cmp_q[0].g != g) begin
              n_miss++;
              $display("FAIL done%0d unexpected pulse at cyc=%0d, expected none", g, cyc);
            end else begin
              mc = cmp_q.pop_front();
              if (mc.cyc != cyc || req_ready[g] !== 1'b0 || rdata[g] !== mc.rdata ||
                  xfer_addr[g] !== mc.xaddr || xfer_data[g] !== mc.xdata || xfer_count[g] !== mc.cnt) begin
                n_miss++;
                $display("FAIL done%0d got cyc=%0d rdy=%b rdata=%h xaddr=%h xdata=%h cnt=%0d, expected cyc=%0d rdy=0 rdata=%h xaddr=%h xdata=%h cnt=%0d",
                         g, cyc, req_ready[g], rdata[g], xfer_addr[g], xfer_data[g], xfer_count[g],
                         mc.cyc, mc.rdata, mc.xaddr, mc.xdata, mc.cnt);
              end
            end
          end else if (cmp_q.size() > 0 && cmp_q[0].g == g && cmp_q[0].cyc <= cyc) begin
            mc = cmp_q.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL done%0d missing pulse: got none by cyc=%0d, expected at cyc=%0d", g, cyc, mc.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input int g, input logic wr, input logic [15:0] a, input logic [2:0] len,
                       input logic [31:0] wd, input bit hold, output int acc);
    req_write[g] = wr;
    req_addr[g]  = a;
    req_len[g]   = len;
    req_wdata[g] = wd;
    req_valid[g] = 1'b1;
    acc = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (req_ready[g] === 1'b1) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    if (!hold) req_valid[g] = 1'b0;
    n_vec++;
    if (acc < 0) begin
      n_miss++;
      $display("FAIL accept%0d: got no accept, expected accept within 64 cycles", g);
    end
  endtask

  task automatic exp_bytes(input int g, input int c0, input logic wr, input logic [15:0] a,
                           input logic [7:0] d, input int n);
    bus_t b;
    for (int i = 0; i < n; i++) begin
      b.g = g; b.cyc = c0 + i; b.rd = ~wr; b.wr = wr; b.addr = a;
      b.data = wr ? d : 8'h00;
      bus_q.push_back(b);
    end
  endtask

  task automatic exp_done(input int g, input int c, input logic [31:0] rd, input logic [63:0] xa,
                          input logic [31:0] xd, input logic [2:0] cnt);
    cmp_t e;
    e.g = g; e.cyc = c; e.rdata = rd; e.xaddr = xa; e.xdata = xd; e.cnt = cnt;
    cmp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 300; n++) begin
      if (bus_q.size() == 0 && cmp_q.size() == 0) break;
      @(posedge clk);
    end
    if (n == 300) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d bus and %0d done items pending, expected 0", bus_q.size(), cmp_q.size());
      bus_q.delete();
      cmp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  initial begin
    int acc, acc2;
    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem1[16'hFFFF] = 8'h12; mem1[16'h0000] = 8'h34;
    mem0[16'h3000] = 8'hA1; mem0[16'h3001] = 8'hB2;
    mem0[16'h6000] = 8'h01; mem0[16'h6001] = 8'h02; mem0[16'h6002] = 8'h03; mem0[16'h6003] = 8'h04;
    mem0[16'h7000] = 8'h9D;
    for (int g = 0; g < 2; g++) begin
      reset_v[g] = 1'b1; req_valid[g] = 1'b0; req_write[g] = 1'b0;
      req_addr[g] = 16'h0; req_len[g] = 3'd0; req_wdata[g] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset_ready%0d", g), 64'(req_ready[g]), 64'd1);
      chk($sformatf("reset_strobes%0d", g), 64'({mem_rd[g], mem_wr[g], done[g]}), 64'd0);
      chk($sformatf("reset_xfer%0d", g), 64'({xfer_count[g], xfer_addr[g]}), 64'd0);
      reset_v[g] = 1'b0;
    end
    mon_on = 1'b1;
    @(posedge clk); #1;

    // LD (nn),dd: little-endian 2-byte write
    issue(0, 1'b1, 16'h1234, 3'd2, 32'h0000_BEEF, 1'b0, acc);
    exp_bytes(0, acc,     1'b1, 16'h1234, 8'hEF, T);
    exp_bytes(0, acc + 3, 1'b1, 16'h1235, 8'hBE, T);
    exp_done(0, acc + 6, 32'h0, 64'h0000_0000_1235_1234, 32'h0000_BEEF, 3'd2);
    drain();

    // Big-endian read wrapping 0xFFFF -> 0x0000
    issue(1, 1'b0, 16'hFFFF, 3'd2, 32'h0, 1'b0, acc);
    exp_bytes(1, acc,     1'b0, 16'hFFFF, 8'h00, T);
    exp_bytes(1, acc + 3, 1'b0, 16'h0000, 8'h00, T);
    exp_done(1, acc + 6, 32'h0000_1234, 64'h0000_0000_0000_FFFF, 32'h0000_3412, 3'd2);
    drain();

    // Big-endian 3-byte write
    issue(1, 1'b1, 16'h4000, 3'd3, 32'h0011_2233, 1'b0, acc);
    exp_bytes(1, acc,     1'b1, 16'h4000, 8'h11, T);
    exp_bytes(1, acc + 3, 1'b1, 16'h4001, 8'h22, T);
    exp_bytes(1, acc + 6, 1'b1, 16'h4002, 8'h33, T);
    exp_done(1, acc + 9, 32'h0, 64'h0000_4002_4001_4000, 32'h0033_2211, 3'd3);
    drain();

    // Two wait cycles on byte 0's last T-state
    issue(0, 1'b0, 16'h3000, 3'd2, 32'h0, 1'b0, acc);
    w_lo = acc + 2; w_hi = acc + 3; w_g = 0;
    exp_bytes(0, acc,     1'b0, 16'h3000, 8'h00, 5);
    exp_bytes(0, acc + 5, 1'b0, 16'h3001, 8'h00, T);
    exp_done(0, acc + 8, 32'h0000_B2A1, 64'h0000_0000_3001_3000, 32'h0000_B2A1, 3'd2);
    drain();
    w_g = -1;

    // len=0: immediate done, stale results cleared
    issue(0, 1'b0, 16'h5000, 3'd0, 32'h0, 1'b0, acc);
    exp_done(0, acc, 32'h0, 64'h0, 32'h0, 3'd0);
    drain();

    // len=7 clamps to 4
    issue(0, 1'b0, 16'h6000, 3'd7, 32'h0, 1'b0, acc);
    for (int k = 0; k < 4; k++) exp_bytes(0, acc + 3*k, 1'b0, 16'h6000 + 16'(k), 8'h00, T);
    exp_done(0, acc + 12, 32'h0403_0201, 64'h6003_6002_6001_6000, 32'h0403_0201, 3'd4);
    drain();

    // Reset during cycle 4 of a 2-byte write
    issue(0, 1'b1, 16'h2000, 3'd2, 32'h0000_A55A, 1'b0, acc);
    exp_bytes(0, acc,     1'b1, 16'h2000, 8'h5A, T);
    exp_bytes(0, acc + 3, 1'b1, 16'h2001, 8'hA5, 1);
    repeat (3) @(posedge clk);
    #1;
    reset_v[0] = 1'b1;
    @(posedge clk); #1;
    reset_v[0] = 1'b0;
    chk("abort_strobes", 64'({mem_rd[0], mem_wr[0], done[0]}), 64'd0);
    chk("abort_ready", 64'(req_ready[0]), 64'd1);
    chk("abort_count", 64'(xfer_count[0]), 64'd0);
    chk("abort_xaddr", xfer_addr[0], 64'd0);
    drain();
    issue(0, 1'b1, 16'h2100, 3'd1, 32'h0000_0077, 1'b0, acc);
    exp_bytes(0, acc, 1'b1, 16'h2100, 8'h77, T);
    exp_done(0, acc + 3, 32'h0, 64'h0000_0000_0000_2100, 32'h0000_0077, 3'd1);
    drain();

    // Back-to-back with req_valid held through DONE
    issue(0, 1'b0, 16'h7000, 3'd1, 32'h0, 1'b1, acc);
    exp_bytes(0, acc, 1'b0, 16'h7000, 8'h00, T);
    exp_done(0, acc + 3, 32'h0000_009D, 64'h0000_0000_0000_7000, 32'h0000_009D, 3'd1);
    issue(0, 1'b1, 16'h7100, 3'd1, 32'h0000_0066, 1'b0, acc2);
    chk("b2b_accept_cyc", 64'(acc2), 64'(acc + 5));
    chk("b2b_rdata_cleared", 64'(rdata[0]), 64'd0);
    exp_bytes(0, acc2, 1'b1, 16'h7100, 8'h66, T);
    exp_done(0, acc2 + 3, 32'h0, 64'h0000_0000_0000_7100, 32'h0000_0066, 3'd1);
    drain();

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
